// File: rtl/jesd_flat_pkg.sv
// Purpose: shared types and helpers for the JESD204C lane gearbox flattener.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package jesd_flat_pkg;

    // Alignment FSM: SEARCH discards beats until a start marker is seen,
    // RUN assembles words.
    typedef enum logic {
        SEARCH = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Beat counter width. RATIO is a power of two and at least 2, so the
    // counter wraps naturally from RATIO-1 back to 0.
    function automatic int cnt_width(input int ratio);
        return $clog2(ratio);
    endfunction

    // LSB position of (lane, beat) inside the flattened output word.
    // Each lane owns a contiguous RATIO*lane_width slice, with the earliest
    // beat at the bottom of that slice.
    function automatic int slice_lsb(input int lane, input int beat,
                                     input int lane_width, input int ratio);
        return lane * lane_width * ratio + beat * lane_width;
    endfunction

endpackage

// File: rtl/jesd_lane_accumulator.sv
// Purpose: per-lane RATIO x LANE_WIDTH beat store with a bypass of the current beat.
// Latency: word is combinational (current beat bypassed); stored slices update on the clock.
// Backpressure: none, a write is accepted whenever wr_en is high.
// Ports: aclk/aresetn clock and async active-low reset; wr_en/beat_idx/beat_dat
//        write one beat into slice beat_idx; word is the assembled lane word.
module jesd_lane_accumulator
    import jesd_flat_pkg::*;
#(
    parameter int LANE_WIDTH = 32,
    parameter int RATIO      = 4,
    parameter int CW         = cnt_width(RATIO)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          wr_en,
    input  logic [CW-1:0]                 beat_idx,
    input  logic [LANE_WIDTH-1:0]         beat_dat,
    output logic [LANE_WIDTH*RATIO-1:0]   word
);

    logic [RATIO-1:0][LANE_WIDTH-1:0] slice;
    logic [RATIO-1:0][LANE_WIDTH-1:0] assembled;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            slice <= '0;
        end else if (wr_en) begin
            slice[beat_idx] <= beat_dat;
        end
    end

    // The final beat of a word is still on the input bus when the word
    // completes, so it is merged in here rather than waiting a cycle.
    always_comb begin
        assembled           = slice;
        assembled[beat_idx] = beat_dat;
    end

    assign word = assembled;

endmodule

// File: rtl/jesd_lane_gearbox_flattener.sv
// Purpose: gathers RATIO per-lane JESD204C beats into one wide sample word, aligned on tuser.
// Latency: 1 cycle from the final beat of a word to m_axis_tvalid.
// Backpressure: input cannot stall; a completed word with no free output slot is dropped and flags overflow.
// Ports: s_axis_* per-lane input beats (tuser = start of multiframe), m_axis_* flattened
//        output stream, overflow/realigned sticky flags cleared by clear_status, aligned = in RUN.
// Config: define JESD_FLAT_SKID_EN for a 2-entry output buffer instead of a single register.
module jesd_lane_gearbox_flattener
    import jesd_flat_pkg::*;
#(
    parameter  int NUM_LANES  = 2,
    parameter  int LANE_WIDTH = 32,
    parameter  int RATIO      = 4,
    localparam int IN_WIDTH   = NUM_LANES * LANE_WIDTH,
    localparam int OUT_WIDTH  = IN_WIDTH * RATIO
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tuser,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 overflow,
    output logic                 realigned,
    output logic                 aligned,
    input  logic                 clear_status
);

    localparam int            CW   = cnt_width(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [CW-1:0]   beat_idx;
    logic            wr_en;
    logic            complete;
    logic            realign_evt;
    logic            push;
    logic            drop;
    logic            pop;
    logic [OUT_WIDTH-1:0] asm_word;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= SEARCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wr_en       = 1'b0;
        beat_idx    = cnt;
        complete    = 1'b0;
        realign_evt = 1'b0;
        case (state)
            SEARCH: begin
                if (s_axis_tvalid && s_axis_tuser) begin
                    wr_en     = 1'b1;
                    beat_idx  = '0;
                    cnt_nxt   = CW'(1);
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (s_axis_tvalid) begin
                    wr_en = 1'b1;
                    // A marker anywhere but beat 0 restarts the word; this
                    // includes the last beat, so that word never completes.
                    if (s_axis_tuser && cnt != '0) begin
                        realign_evt = 1'b1;
                        beat_idx    = '0;
                        cnt_nxt     = CW'(1);
                    end else if (cnt == LAST) begin
                        complete = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        jesd_lane_accumulator #(
            .LANE_WIDTH (LANE_WIDTH),
            .RATIO      (RATIO),
            .CW         (CW)
        ) u_acc (
            .aclk     (aclk),
            .aresetn  (aresetn),
            .wr_en    (wr_en),
            .beat_idx (beat_idx),
            .beat_dat (s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH]),
            .word     (asm_word[slice_lsb(i, 0, LANE_WIDTH, RATIO) +: LANE_WIDTH*RATIO])
        );
    end

    assign pop = m_axis_tvalid & m_axis_tready;

`ifdef JESD_FLAT_SKID_EN
    // Two-entry FIFO; ent0 is always the head presented downstream.
    logic [OUT_WIDTH-1:0] ent0, ent1;
    logic [1:0]           occ;

    assign push = complete && (occ != 2'd2 || pop);
    assign drop = complete && !push;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (occ == 2'd1) begin
                        ent0 <= asm_word;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= asm_word;
                    end
                end
                2'b10: begin
                    if (occ == 2'd0) ent0 <= asm_word;
                    else             ent1 <= asm_word;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = ent0;
`else
    logic                 out_vld;
    logic [OUT_WIDTH-1:0] out_dat;

    // The register is free when empty or when its word leaves this cycle.
    assign push = complete && (!out_vld || pop);
    assign drop = complete && !push;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (push) begin
            out_vld <= 1'b1;
            out_dat <= asm_word;
        end else if (pop) begin
            out_vld <= 1'b0;
        end
    end

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_dat;
`endif

    // Set beats clear when both land on the same edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow  <= 1'b0;
            realigned <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clear_status) | drop;
            realigned <= (realigned & ~clear_status) | realign_evt;
        end
    end

    assign aligned = (state == RUN);

endmodule

// File: tb/tb_jesd_lane_gearbox_flattener.sv
// Purpose: randomized and directed bench for jesd_lane_gearbox_flattener with a queue-based reference model.
// Latency: expected words enter the scoreboard on the edge that completes them.
// Backpressure: models output occupancy to predict drops and the overflow flag.
module tb_jesd_lane_gearbox_flattener;

    localparam int NL    = 2;
    localparam int LW    = 32;
    localparam int R     = 4;
    localparam int IN_W  = NL * LW;
    localparam int OUT_W = IN_W * R;
`ifdef JESD_FLAT_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [IN_W-1:0]  s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tuser;
    logic [OUT_W-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             overflow;
    logic             realigned;
    logic             aligned;
    logic             clear_status;

    always #5 aclk = ~aclk;

    jesd_lane_gearbox_flattener #(
        .NUM_LANES  (NL),
        .LANE_WIDTH (LW),
        .RATIO      (R)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .realigned     (realigned),
        .aligned       (aligned),
        .clear_status  (clear_status)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard of words expected to be sitting in / leaving the DUT output.
    logic [OUT_W-1:0] sb[$];
    logic [OUT_W-1:0] last_word = '0;

    // Reference model state.
    bit              m_aligned;
    logic [IN_W-1:0] m_beats[$];
    int              m_occ;
    bit              exp_ovf;
    bit              exp_rea;

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] build_word();
        logic [OUT_W-1:0] w;
        w = '0;
        for (int i = 0; i < NL; i++)
            for (int k = 0; k < R; k++)
                w[i*LW*R + k*LW +: LW] = m_beats[k][i*LW +: LW];
        return w;
    endfunction

    function automatic logic [IN_W-1:0] beat(input logic [LW-1:0] l0, input logic [LW-1:0] l1);
        return {l1, l0};
    endfunction

    function automatic logic [IN_W-1:0] rnd_beat();
        return {$urandom, $urandom};
    endfunction

    // Drive one cycle, advance the model across the edge, then check flags.
    task automatic step(input bit vld, input bit usr, input logic [IN_W-1:0] dat,
                        input bit rdy, input bit clr);
        int               occ;
        bit               push, ovf_evt, rea_evt;
        logic [OUT_W-1:0] w;
        s_axis_tvalid = vld;
        s_axis_tuser  = usr;
        s_axis_tdata  = dat;
        m_axis_tready = rdy;
        clear_status  = clr;
        occ     = m_occ - ((m_occ > 0 && rdy) ? 1 : 0);
        push    = 1'b0;
        ovf_evt = 1'b0;
        rea_evt = 1'b0;
        w       = '0;
        if (vld) begin
            if (!m_aligned) begin
                if (usr) begin
                    m_aligned = 1'b1;
                    m_beats.delete();
                    m_beats.push_back(dat);
                end
            end else if (usr && m_beats.size() != 0) begin
                m_beats.delete();
                m_beats.push_back(dat);
                rea_evt = 1'b1;
            end else begin
                m_beats.push_back(dat);
                if (m_beats.size() == R) begin
                    w = build_word();
                    m_beats.delete();
                    if (occ < DEPTH) begin
                        occ++;
                        push = 1'b1;
                    end else begin
                        ovf_evt = 1'b1;
                    end
                end
            end
        end
        m_occ   = occ;
        exp_ovf = (exp_ovf && !clr) || ovf_evt;
        exp_rea = (exp_rea && !clr) || rea_evt;
        @(posedge aclk);
        if (push) sb.push_back(w);
        #1;
        chk("aligned",   OUT_W'(aligned),   OUT_W'(m_aligned));
        chk("overflow",  OUT_W'(overflow),  OUT_W'(exp_ovf));
        chk("realigned", OUT_W'(realigned), OUT_W'(exp_rea));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        clear_status  = 1'b0;
        #2;
        chk("rst_tdata",     m_axis_tdata,            '0);
        chk("rst_tvalid",    OUT_W'(m_axis_tvalid),   '0);
        chk("rst_overflow",  OUT_W'(overflow),        '0);
        chk("rst_realigned", OUT_W'(realigned),       '0);
        chk("rst_aligned",   OUT_W'(aligned),         '0);
        sb.delete();
        m_beats.delete();
        m_aligned = 1'b0;
        m_occ     = 0;
        exp_ovf   = 1'b0;
        exp_rea   = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // Monitor: whenever the DUT is quiescent between edges, its output must
    // match the scoreboard head; an accepted word retires it.
    always @(negedge aclk) begin
        if (aresetn) begin
            checks++;
            if (m_axis_tvalid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL tvalid: got %b expected %b", m_axis_tvalid, (sb.size() != 0));
            end
            if (m_axis_tvalid && sb.size() != 0) begin
                chk("tdata", m_axis_tdata, sb[0]);
                if (m_axis_tready) last_word = sb.pop_front();
            end
        end
    end

    logic [OUT_W-1:0] t1_exp;

    initial begin
        do_reset();

        // Directed word with known lane contents.
        t1_exp = {32'h13, 32'h12, 32'h11, 32'h10, 32'h3, 32'h2, 32'h1, 32'h0};
        step(1'b1, 1'b1, beat(32'h0, 32'h10), 1'b1, 1'b0);
        step(1'b1, 1'b0, beat(32'h1, 32'h11), 1'b1, 1'b0);
        step(1'b1, 1'b0, beat(32'h2, 32'h12), 1'b1, 1'b0);
        step(1'b1, 1'b0, beat(32'h3, 32'h13), 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("first_word", last_word, t1_exp);

        // Beats before any marker are discarded.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd_beat(), 1'b1, 1'b0);
        step(1'b1, 1'b1, rnd_beat(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd_beat(), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Marker on the second beat of a word realigns.
        step(1'b1, 1'b1, rnd_beat(), 1'b1, 1'b0);
        step(1'b1, 1'b1, rnd_beat(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd_beat(), 1'b1, 1'b0);
        idle(2, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Stalled output with two back-to-back words.
        step(1'b1, 1'b1, rnd_beat(), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, rnd_beat(), 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Sparse input: one valid beat every third cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), rnd_beat(), 1'b1, 1'b0);
            idle(2, 1'b1);
        end
        idle(2, 1'b1);

        // Reset in the middle of a word.
        step(1'b1, 1'b1, rnd_beat(), 1'b1, 1'b0);
        step(1'b1, 1'b0, rnd_beat(), 1'b1, 1'b0);
        do_reset();
        step(1'b1, 1'b0, rnd_beat(), 1'b1, 1'b0);

        // Overflow event coinciding with clear_status keeps the flag set.
        step(1'b1, 1'b1, rnd_beat(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, rnd_beat(), 1'b0, 1'b0);
        step(1'b1, 1'b0, rnd_beat(), 1'b0, 1'b1);
        idle(4, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rnd_beat(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        idle(6, 1'b1);
        chk("drain_empty", OUT_W'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
